// File: rtl/apb_slave_mem_if.sv
// APB completer bus bundle: request signals from the master, response from the memory slave.
interface apb_slave_mem_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  i_psel;
    logic                  i_penable;
    logic                  i_pwrite;
    logic [ADDR_WIDTH-1:0] i_paddr;
    logic [DATA_WIDTH-1:0] i_pwdata;
    logic [STRB_W-1:0]     i_pstrb;
    logic [DATA_WIDTH-1:0] o_prdata;
    logic                  o_pready;
    logic                  o_pslverr;

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
        input  o_prdata, o_pready, o_pslverr
    );

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
        output o_prdata, o_pready, o_pslverr
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer with a small word-addressed register memory, programmable wait
// states and PSLVERR on out-of-range or misaligned addresses.
// Optional byte-strobe writes: define APB_SLV_PSTRB_EN.
module apb_slave_mem #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic            i_clk_apb,
    input  logic            i_rst_apb,
    apb_slave_mem_if.slave  slv
);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [IDX_W-1:0]      idx_c;
    logic                  legal_c;
    logic                  setup_c;
    logic [DATA_WIDTH-1:0] wr_word_c;

    // Address decode: word index plus alignment / upper-bit range check
    assign idx_c   = slv.i_paddr[IDX_W+1:2];
    assign legal_c = (slv.i_paddr[1:0] == 2'b00) &&
                     ((slv.i_paddr >> (IDX_W + 2)) == '0);
    assign setup_c = slv.i_psel && !slv.i_penable;

`ifdef APB_SLV_PSTRB_EN
    logic [STRB_W-1:0] strb_q;

    // Merge latched write data into the current word under the byte strobes
    always_comb begin
        wr_word_c = mem[idx_q];
        for (int k = 0; k < int'(STRB_W); k++) begin
            if (strb_q[k]) begin
                wr_word_c[8*k +: 8] = wdata_q[8*k +: 8];
            end
        end
    end
`else
    logic unused_pstrb_c;

    assign wr_word_c      = wdata_q;
    assign unused_pstrb_c = ^slv.i_pstrb;
`endif

    // Transfer FSM, wait counter, response registers and memory array
    always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
        if (i_rst_apb) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
`ifdef APB_SLV_PSTRB_EN
            strb_q  <= '0;
`endif
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    if (setup_c) begin
                        state   <= ACCESS;
                        cnt     <= CNT_W'(WAIT_STATES);
                        idx_q   <= idx_c;
                        wr_q    <= slv.i_pwrite;
                        err_q   <= !legal_c;
                        wdata_q <= slv.i_pwdata;
                        rdata_q <= mem[idx_c];
`ifdef APB_SLV_PSTRB_EN
                        strb_q  <= slv.i_pstrb;
`endif
                        // Zero wait states: response is ready in the first access cycle
                        if (WAIT_STATES == 0) begin
                            pready  <= 1'b1;
                            pslverr <= !legal_c;
                            prdata  <= (legal_c && !slv.i_pwrite) ? mem[idx_c] : '0;
                        end
                    end
                end

                ACCESS: begin
                    if (!slv.i_psel) begin
                        // Aborted transfer: drop everything, no write
                        state   <= IDLE;
                        cnt     <= '0;
                        prdata  <= '0;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            pready  <= 1'b1;
                            pslverr <= err_q;
                            prdata  <= (!err_q && !wr_q) ? rdata_q : '0;
                        end
                    end else if (slv.i_penable) begin
                        // Completion: commit a legal write, then release the bus
                        if (wr_q && !err_q) begin
                            mem[idx_q] <= wr_word_c;
                        end
                        state   <= IDLE;
                        prdata  <= '0;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    prdata  <= '0;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end

    assign slv.o_prdata  = prdata;
    assign slv.o_pready  = pready;
    assign slv.o_pslverr = pslverr;

endmodule
